cpu_bus_arbiter: RTL

- Shares one CPU-side memory bus between two requesters: port A (instruction fetch) and port B (data memory stage, i.e. the dcache/bus side of the memory stage).
- Both ports use the codebase bus handshake (rw/request/ready/address/rdata/wdata).
- Grants one transaction at a time, holds the grant until the slave signals ready, then re-arbitrates.
- Sits between the CPU fetch and memory stages and the system bus interconnect.

---
 rtl/cpu_bus_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// Two-port arbiter that shares one CPU memory bus between instruction fetch (A) and data (B).
// Define CPU_BUS_ARBITER_ROUND_ROBIN_EN to resolve simultaneous requests with a rotating pointer.
module cpu_bus_arbiter #(
  parameter int unsigned PRIORITY_B  = 0,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_pa_rw,
  input  logic                   i_pa_request,
  output logic                   o_pa_ready,
  input  logic [31:0]            i_pa_address,
  output logic [31:0]            o_pa_rdata,
  input  logic [31:0]            i_pa_wdata,
  input  logic                   i_pb_rw,
  input  logic                   i_pb_request,
  output logic                   o_pb_ready,
  input  logic [31:0]            i_pb_address,
  output logic [31:0]            o_pb_rdata,
  input  logic [31:0]            i_pb_wdata,
  output logic                   o_bus_rw,
  output logic                   o_bus_request,
  input  logic                   i_bus_ready,
  output logic [31:0]            o_bus_address,
  input  logic [31:0]            i_bus_rdata,
  output logic [31:0]            o_bus_wdata,
  output logic [1:0]             o_grant,
  output logic [COUNT_WIDTH-1:0] o_pa_count,
  output logic [COUNT_WIDTH-1:0] o_pb_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [COUNT_WIDTH-1:0] pa_count_q, pa_count_d;
  logic [COUNT_WIDTH-1:0] pb_count_q, pb_count_d;
  logic                   prefer_b;
  logic                   win_b;

`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
  // rr_q names the port preferred on the next tie (0 = A, 1 = B).
  logic rr_q, rr_d;
  assign prefer_b = rr_q;
`else
  assign prefer_b = (PRIORITY_B != 0);
`endif

  assign win_b = i_pb_request & (~i_pa_request | prefer_b);

  always_comb begin
    state_d    = state_q;
    pa_count_d = pa_count_q;
    pb_count_d = pb_count_q;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_pa_request || i_pb_request) begin
          state_d = win_b ? GRANT_B : GRANT_A;
        end
      end
      GRANT_A: begin
        if (i_bus_ready) begin
          state_d    = IDLE;
          pa_count_d = pa_count_q + COUNT_WIDTH'(1);
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
          rr_d       = 1'b1;
`endif
        end else if (!i_pa_request) begin
          state_d = IDLE;
        end
      end
      GRANT_B: begin
        if (i_bus_ready) begin
          state_d    = IDLE;
          pb_count_d = pb_count_q + COUNT_WIDTH'(1);
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
          rr_d       = 1'b0;
`endif
        end else if (!i_pb_request) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == GRANT_B, state_d == GRANT_A};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      pa_count_q <= '0;
      pb_count_q <= '0;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pa_count_q <= pa_count_d;
      pb_count_q <= pb_count_d;
`ifdef CPU_BUS_ARBITER_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  // The bus follows the owner combinationally so an abort drops o_bus_request in the same cycle.
  always_comb begin
    o_bus_rw      = 1'b0;
    o_bus_request = 1'b0;
    o_bus_address = '0;
    o_bus_wdata   = '0;
    o_pa_ready    = 1'b0;
    o_pa_rdata    = '0;
    o_pb_ready    = 1'b0;
    o_pb_rdata    = '0;
    case (state_q)
      GRANT_A: begin
        o_bus_rw      = i_pa_rw;
        o_bus_request = i_pa_request;
        o_bus_address = i_pa_address;
        o_bus_wdata   = i_pa_wdata;
        o_pa_ready    = i_bus_ready;
        o_pa_rdata    = i_bus_rdata;
      end
      GRANT_B: begin
        o_bus_rw      = i_pb_rw;
        o_bus_request = i_pb_request;
        o_bus_address = i_pb_address;
        o_bus_wdata   = i_pb_wdata;
        o_pb_ready    = i_bus_ready;
        o_pb_rdata    = i_bus_rdata;
      end
      default: ;
    endcase
  end

  assign o_grant    = grant_q;
  assign o_pa_count = pa_count_q;
  assign o_pb_count = pb_count_q;

endmodule
